// File: rtl/game_sequencer_pkg.sv
// Shared definitions for the tic-tac-toe sequencer: symbol codes, FSM state
// codes and the table of the eight winning lines.
package game_sequencer_pkg;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] X     = 2'b01;
  localparam logic [1:0] O     = 2'b10;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WRITE  = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] CHECK  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;
  localparam logic [2:0] CLEAR  = 3'd5;

  localparam logic [3:0] MAX_MOVES = 4'd9;
  localparam logic [2:0] LAST_LINE = 3'd7;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
  } line_cells_t;

  // Cell numbers (3*row + col) of each line, in scan order: rows, cols, diagonals.
  function automatic line_cells_t line_cells(input logic [2:0] idx);
    line_cells_t l;
    case (idx)
      3'd0:    l = '{a: 4'd0, b: 4'd1, c: 4'd2};
      3'd1:    l = '{a: 4'd3, b: 4'd4, c: 4'd5};
      3'd2:    l = '{a: 4'd6, b: 4'd7, c: 4'd8};
      3'd3:    l = '{a: 4'd0, b: 4'd3, c: 4'd6};
      3'd4:    l = '{a: 4'd1, b: 4'd4, c: 4'd7};
      3'd5:    l = '{a: 4'd2, b: 4'd5, c: 4'd8};
      3'd6:    l = '{a: 4'd0, b: 4'd4, c: 4'd8};
      default: l = '{a: 4'd2, b: 4'd4, c: 4'd6};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/game_sequencer_line_checker.sv
// Combinational test of one board line: a win is three equal, non-empty cells.
module line_checker
  import game_sequencer_pkg::*;
(
  input  logic [1:0] cell_a,
  input  logic [1:0] cell_b,
  input  logic [1:0] cell_c,
  output logic       win,
  output logic [1:0] symbol
);

  always_comb begin
    win    = (cell_a != EMPTY) && (cell_a == cell_b) && (cell_b == cell_c);
    symbol = win ? cell_a : EMPTY;
  end

endmodule

// File: rtl/game_sequencer.sv
// Move sequencer for a 3x3 game: validates requests, strobes board writes,
// then scans one line per cycle for a winner or a draw.
module game_sequencer
  import game_sequencer_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [0:17] iSymVector,
  input  logic        iMoveReq,
  input  logic [1:0]  iPosX,
  input  logic [1:0]  iPosY,
  input  logic        iRestart,
  output logic        oWriteEn,
  output logic [1:0]  oWriteRow,
  output logic [1:0]  oWriteCol,
  output logic [1:0]  oWriteSym,
  output logic        oClearBoard,
  output logic [1:0]  oTurn,
  output logic [1:0]  oWinner,
  output logic        oGameOver,
  output logic        oDraw,
  output logic        oBusy,
  output logic        oMoveReject
);

  logic [2:0]  state;
  logic [3:0]  move_count;
  logic [2:0]  line_idx;
  logic [1:0]  cells [9];
  logic        move_legal;
  logic [3:0]  target;
  logic        target_empty;
  line_cells_t line_sel;
  logic [1:0]  cell_a;
  logic [1:0]  cell_b;
  logic [1:0]  cell_c;
  logic        line_win;
  logic [1:0]  line_sym;

  // Cell 0 sits in the lowest-numbered (most significant) bits of the snapshot.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      cells[i] = iSymVector[2*i +: 2];
    end
  end

  always_comb begin
    move_legal = (iPosX != 2'd3) && (iPosY != 2'd3);
    target     = 4'd0;
    if (move_legal) begin
      target = ({2'b00, iPosY} * 4'd3) + {2'b00, iPosX};
    end
    target_empty = move_legal && (cells[target] == EMPTY);
  end

  always_comb begin
    line_sel = line_cells(line_idx);
    cell_a   = cells[line_sel.a];
    cell_b   = cells[line_sel.b];
    cell_c   = cells[line_sel.c];
  end

  line_checker u_line_checker (
    .cell_a (cell_a),
    .cell_b (cell_b),
    .cell_c (cell_c),
    .win    (line_win),
    .symbol (line_sym)
  );

  assign oBusy = (state != IDLE) && (state != DONE);

  // Strobes default low every cycle; a restart overrides whatever state is doing.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      move_count  <= 4'd0;
      line_idx    <= 3'd0;
      oWriteEn    <= 1'b0;
      oWriteRow   <= 2'd0;
      oWriteCol   <= 2'd0;
      oWriteSym   <= EMPTY;
      oClearBoard <= 1'b0;
      oTurn       <= X;
      oWinner     <= EMPTY;
      oGameOver   <= 1'b0;
      oDraw       <= 1'b0;
      oMoveReject <= 1'b0;
    end else begin
      oWriteEn    <= 1'b0;
      oClearBoard <= 1'b0;
      oMoveReject <= 1'b0;
      if (iRestart) begin
        state       <= CLEAR;
        oClearBoard <= 1'b1;
        move_count  <= 4'd0;
        oTurn       <= X;
        oWinner     <= EMPTY;
        oGameOver   <= 1'b0;
        oDraw       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (iMoveReq) begin
              if (target_empty) begin
                oWriteRow <= iPosY;
                oWriteCol <= iPosX;
                oWriteSym <= oTurn;
                oWriteEn  <= 1'b1;
                state     <= WRITE;
              end else begin
                oMoveReject <= 1'b1;
              end
            end
          end
          WRITE: begin
            if (move_count != MAX_MOVES) begin
              move_count <= move_count + 4'd1;
            end
            state <= SETTLE;
          end
          SETTLE: begin
            line_idx <= 3'd0;
            state    <= CHECK;
          end
          // First winning line ends the scan; otherwise the full scan decides draw vs next turn.
          CHECK: begin
            if (line_win) begin
              oWinner   <= line_sym;
              oGameOver <= 1'b1;
              state     <= DONE;
            end else if (line_idx == LAST_LINE) begin
              if (move_count == MAX_MOVES) begin
                oDraw     <= 1'b1;
                oGameOver <= 1'b1;
                state     <= DONE;
              end else begin
                oTurn <= (oTurn == X) ? O : X;
                state <= IDLE;
              end
            end else begin
              line_idx <= line_idx + 3'd1;
            end
          end
          DONE: begin
            if (iMoveReq) begin
              oMoveReject <= 1'b1;
            end
          end
          CLEAR: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter none; symbol encodings EMPTY=2'b00, X=2'b01, O=2'b10 come from the shared definitions file.
REQ-002 Clock  input  1  system clock; all state updates on rising edge.
REQ-003 Reset  input  1  reset, asynchronous, active-high.
REQ-004 iSymVector  input  [0:17]  board snapshot; index 0 is MSB; cell (row r, col c) at bits [2*(3r+c) +: 2].
REQ-005 iMoveReq  input  1  one-cycle move request at (iPosY, iPosX).
REQ-006 iPosX, iPosY  input  2 each  requested column/row, 0..2 legal.
REQ-007 iRestart  input  1  one-cycle request to clear board and start a new game.
REQ-008 oWriteEn  output  1  one-cycle board write strobe.
REQ-009 oWriteRow, oWriteCol  output  2 each  latched target cell for the write.
REQ-010 oWriteSym  output  2  symbol to write (equals oTurn at accept time).
REQ-011 oClearBoard  output  1  one-cycle strobe: board sets all cells to EMPTY.
REQ-012 oTurn  output  2  symbol whose move is next (X or O).
REQ-013 oWinner  output  2  winning symbol, EMPTY if none.
REQ-014 oGameOver, oDraw  output  1 each  game finished / finished without winner.
REQ-015 oBusy  output  1  high in every state except IDLE and DONE.
REQ-016 oMoveReject  output  1  one-cycle pulse on a refused move request.

Function
REQ-017 FSM states: IDLE, WRITE, SETTLE, CHECK, DONE, CLEAR; registered state, one transition per clock.
REQ-018 IDLE: iMoveReq with iPosX<=2, iPosY<=2 and addressed cell EMPTY -> latch position and oTurn, go WRITE.
REQ-019 IDLE: iMoveReq with coordinate 3 or non-EMPTY cell -> oMoveReject high next cycle for one cycle, stay IDLE.
REQ-020 WRITE: oWriteEn=1 for exactly this one cycle; 4-bit move counter increments; go SETTLE.
REQ-021 SETTLE: one cycle, no outputs change, lets board reflect the write; go CHECK with 3-bit line index = 0.
REQ-022 CHECK: one line per cycle, order rows 0-2, cols 0-2, main diagonal (0,0)(1,1)(2,2), anti-diagonal (0,2)(1,1)(2,0).
REQ-023 Line wins when its three cells are equal and not EMPTY; on first win: oWinner=that symbol, oGameOver=1, go DONE (early exit).
REQ-024 After index 7 with no win: move counter==9 -> oDraw=1, oGameOver=1, go DONE; else toggle oTurn (X<->O), go IDLE.
REQ-025 Latency: request sampled at edge k -> oWriteEn during cycle k+1 -> CHECK cycles k+3..k+10 max -> IDLE/DONE by edge k+11.
REQ-026 iMoveReq in WRITE, SETTLE, CHECK, CLEAR is ignored: no reject, no queueing.
REQ-027 DONE: holds oWinner/oDraw/oGameOver; iMoveReq -> oMoveReject pulse; leaves only via iRestart.
REQ-028 iRestart in any state has priority over iMoveReq and an in-progress check: go CLEAR next edge.
REQ-029 CLEAR: oClearBoard=1 one cycle; move counter=0, oTurn=X, oWinner=EMPTY, oGameOver=0, oDraw=0; go IDLE.
REQ-030 Move counter saturates at 9; line index wraps 7->0 only on CHECK entry.

Reset
REQ-031 Reset asserted: state=IDLE, oTurn=X, oWinner=EMPTY, oGameOver=0, oDraw=0, oWriteEn=0, oClearBoard=0, oMoveReject=0, oBusy=0, oWriteRow=oWriteCol=0, oWriteSym=EMPTY, counters 0.
REQ-032 Reset mid-CHECK or mid-WRITE aborts immediately; no write or clear strobe emitted on deassertion; board contents untouched by this block.

Structure
REQ-033 State encodings and symbol macros (EMPTY, X, O) in the shared definitions file; no local redefinition.
REQ-034 One sub-module line_checker: combinational, three 2-bit cells in, 1-bit win and 2-bit symbol out; line cell selection by index stays in game_sequencer.
REQ-035 All outputs registered; oBusy decoded from registered state.

Verification
REQ-036 Empty board, iMoveReq (Y=1,X=1) -> oWriteEn one cycle later, row=1,col=1,sym=X; IDLE by 11 cycles; oTurn=O.
REQ-037 Board with (0,0)=X, iMoveReq (0,0) -> oMoveReject one cycle, no oWriteEn; iPosX=3 -> same.
REQ-038 Board X at (0,0),(0,1),(0,2) after last write -> oWinner=X, oGameOver=1 after first CHECK cycle (row 0).
REQ-039 Nine moves, board X O X / X O O / O X X, no line -> oDraw=1, oWinner=EMPTY, oGameOver=1.
REQ-040 iRestart and iMoveReq same cycle during CHECK -> CLEAR next edge, oClearBoard one cycle, oTurn=X, no oWriteEn.
REQ-041 Reset asserted in WRITE -> all outputs at REQ-031 values same cycle (asynchronous), IDLE after release.
